// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: opcodes, FSM states,
// default parameters and the queued command layout.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ROT = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_MUL = 2'b11
  } calc_op_e;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } calc_state_e;

  localparam int unsigned DEF_FIFO_DEPTH     = 4;
  localparam int unsigned DEF_VALID_CYCLES   = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
  } calc_cmd_t;

  localparam int unsigned CMD_W = $bits(calc_cmd_t);

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous command queue without bypass; read data is the head entry and is
// valid whenever empty is low.
module calc_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Queues host commands and sequences them one at a time into the calculator,
// returning each result (or a timeout/abort error) through a valid/ready port.
//
// state  | meaning
// INIT   | calculator initializing, queue still accepts commands
// IDLE   | waiting for a queued command
// ISSUE  | OpCodeValid strobe held for VALID_CYCLES
// WAIT   | waiting for DataReady rising edge, bounded by TIMEOUT_CYCLES
// RESULT | result held until consumer accepts
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned VALID_CYCLES   = DEF_VALID_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_a,
  input  logic [4:0] cmd_b,
  output logic [4:0] A,
  output logic [4:0] B,
  output logic [1:0] OpCode,
  output logic       OpCodeValid,
  input  logic [4:0] Z,
  input  logic       DataReady,
  input  logic       Initializing,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_data,
  output logic [1:0] res_op,
  output logic       res_err
);

  localparam logic [3:0] VCNT_LOAD = 4'(VALID_CYCLES - 1);
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  calc_state_e state;
  calc_cmd_t   fifo_wdata;
  calc_cmd_t   fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [3:0]  vcnt;
  logic [7:0]  tcnt;
  logic        dr_q;
  logic        dr_rise;
  logic        fin;
  logic        fin_err;
  logic [4:0]  fin_data;

  assign cmd_ready  = !fifo_full;
  assign fifo_wdata = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty && !Initializing;

  calc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (cmd_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Only a fresh 0->1 transition completes, so a DataReady level left high by
  // the previous operation cannot retire the next one.
  assign dr_rise = DataReady && !dr_q;

  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
      if (Initializing) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end else if (dr_rise) begin
        fin      = 1'b1;
        fin_data = Z;
      end else if ((state == ST_WAIT) && (tcnt == TCNT_LAST)) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= ST_INIT;
      A           <= '0;
      B           <= '0;
      OpCode      <= '0;
      OpCodeValid <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= '0;
      res_err     <= 1'b0;
      vcnt        <= '0;
      tcnt        <= '0;
      dr_q        <= 1'b0;
    end else begin
      dr_q <= DataReady;
      case (state)
        ST_INIT: begin
          if (!Initializing) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (Initializing) begin
            state <= ST_INIT;
          end else if (!fifo_empty) begin
            A           <= fifo_rdata.a;
            B           <= fifo_rdata.b;
            OpCode      <= fifo_rdata.op;
            OpCodeValid <= 1'b1;
            vcnt        <= VCNT_LOAD;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (fin) begin
            OpCodeValid <= 1'b0;
            res_valid   <= 1'b1;
            res_data    <= fin_data;
            res_op      <= OpCode;
            res_err     <= fin_err;
            state       <= ST_RESULT;
          end else if (state == ST_ISSUE) begin
            if (vcnt == '0) begin
              OpCodeValid <= 1'b0;
              tcnt        <= '0;
              state       <= ST_WAIT;
            end else begin
              vcnt <= vcnt - 1'b1;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= Initializing ? ST_INIT : ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer with a transaction-level model checked
// every cycle, plus literal checks on the key scenarios.
module tb_calc_cmd_sequencer;

  localparam int FIFO_DEPTH     = 4;
  localparam int VALID_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 64;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_a;
  logic [4:0] cmd_b;
  logic [4:0] A;
  logic [4:0] B;
  logic [1:0] OpCode;
  logic       OpCodeValid;
  logic [4:0] Z;
  logic       DataReady;
  logic       Initializing;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_data;
  logic [1:0] res_op;
  logic       res_err;

  calc_cmd_sequencer #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .VALID_CYCLES   (VALID_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .A            (A),
    .B            (B),
    .OpCode       (OpCode),
    .OpCodeValid  (OpCodeValid),
    .Z            (Z),
    .DataReady    (DataReady),
    .Initializing (Initializing),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_op       (res_op),
    .res_err      (res_err)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Calculator behaviour assumed by this bench (rotate = rotate-left by one).
  function automatic logic [4:0] calc_z(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    logic [9:0] p;
    p = a * b;
    case (op)
      2'd0:    return {a[3:0], a[4]};
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return p[4:0];
    endcase
  endfunction

  typedef struct {
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
  } cmd_t;

  // Scenario knobs: calc_mode 0 = calculator answers, 1 = calculator silent.
  int calc_mode    = 0;
  int resp_delay   = 3;
  bit hold_dr      = 1'b0;
  bit abort_flag   = 1'b0;

  cmd_t       mq[$];
  cmd_t       cur;
  cmd_t       m_drv;
  bit         inflight  = 1'b0;
  logic       ov_prev   = 1'b0;
  logic       rv_prev   = 1'b0;
  bit         m_rst;
  bit         m_acc;
  bit         m_racc;
  int         cyc       = 0;
  int         fall_cyc  = 0;
  int         width     = 0;
  int         rise_cnt  = 0;
  int         n_results = 0;
  logic [4:0] exp_data  = '0;
  logic       exp_err   = 1'b0;

  always @(posedge Clk) begin
    m_rst     = Rst;
    m_acc     = cmd_valid && (mq.size() < FIFO_DEPTH);
    m_racc    = res_ready && rv_prev;
    m_drv.op  = cmd_op;
    m_drv.a   = cmd_a;
    m_drv.b   = cmd_b;
    #1;
    cyc++;
    if (m_rst) begin
      mq.delete();
      inflight = 1'b0;
      ov_prev  = 1'b0;
      rv_prev  = 1'b0;
      check("reset_state",
            {cmd_ready, A, B, OpCode, OpCodeValid, res_valid, res_data, res_op, res_err},
            {1'b1, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0});
    end else begin
      if (m_acc) mq.push_back(m_drv);
      if (m_racc) begin
        inflight = 1'b0;
        n_results++;
      end
      if (OpCodeValid && !ov_prev) begin
        rise_cnt++;
        check("issue_while_busy", {31'd0, inflight}, 32'd0);
        n_tests++;
        if (mq.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_issue: got issue of A=%0h B=%0h op=%0h, expected empty queue", A, B, OpCode);
        end else begin
          cur = mq.pop_front();
        end
        inflight = 1'b1;
        width    = 0;
      end
      if (OpCodeValid) width++;
      if (!OpCodeValid && ov_prev) begin
        check("ov_width", width, VALID_CYCLES);
        fall_cyc = cyc;
      end
      if (inflight) check("operands", {A, B, OpCode}, {cur.a, cur.b, cur.op});
      if (res_valid && !rv_prev) begin
        check("result_has_op", {31'd0, inflight}, 32'd1);
        if (abort_flag || calc_mode == 1) begin
          exp_data = '0;
          exp_err  = 1'b1;
        end else begin
          exp_data = calc_z(cur.op, cur.a, cur.b);
          exp_err  = 1'b0;
        end
        if (!abort_flag)
          check("result_latency", cyc - fall_cyc, (calc_mode == 1) ? TIMEOUT_CYCLES : resp_delay + 1);
      end
      if (res_valid) check("result", {res_data, res_op, res_err}, {exp_data, cur.op, exp_err});
      if (!inflight) check("idle_no_result", {31'd0, res_valid}, 32'd0);
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, mq.size() < FIFO_DEPTH});
      ov_prev = OpCodeValid;
      rv_prev = res_valid;
    end
  end

  // Calculator stand-in: answers a fixed number of cycles after the strobe falls.
  logic calc_ovq = 1'b0;
  initial begin
    DataReady = 1'b0;
    Z         = '0;
    forever begin
      @(negedge Clk);
      if (!hold_dr) DataReady = 1'b0;
      if (calc_ovq && !OpCodeValid && !Rst && calc_mode == 0) begin
        repeat (resp_delay) @(negedge Clk);
        Z         = calc_z(OpCode, A, B);
        DataReady = 1'b1;
      end
      calc_ovq = OpCodeValid;
    end
  end

  task automatic push(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b, output bit ok);
    @(negedge Clk);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    ok        = cmd_ready;
    @(negedge Clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_results < target && k < budget) begin
      @(negedge Clk);
      k++;
    end
    check(name, n_results, target);
  endtask

  task automatic wait_rv(input int budget, input string name);
    int k;
    k = 0;
    @(negedge Clk);
    while (!res_valid && k < budget) begin
      @(negedge Clk);
      k++;
    end
    check(name, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic wait_ov(input logic level, input int budget, input string name);
    int k;
    k = 0;
    while (OpCodeValid !== level && k < budget) begin
      @(negedge Clk);
      k++;
    end
    check(name, {31'd0, OpCodeValid}, {31'd0, level});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  logic [1:0] i_op[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [4:0] i_a[5]  = '{5'd1, 5'd9, 5'd4, 5'd16, 5'd31};
  logic [4:0] i_b[5]  = '{5'd2, 5'd3, 5'd5, 5'd0, 5'd31};
  logic [1:0] p_op[3] = '{2'd0, 2'd2, 2'd3};
  logic [4:0] p_a[3]  = '{5'd19, 5'd3, 5'd7};
  logic [4:0] p_b[3]  = '{5'd0, 5'd5, 5'd6};
  logic [4:0] p_z[3]  = '{5'd7, 5'd30, 5'd10};

  initial begin
    bit ok;
    int base;
    int r0;
    Rst          = 1'b1;
    Initializing = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = '0;
    cmd_a        = '0;
    cmd_b        = '0;
    res_ready    = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    check("model_rot", {27'd0, calc_z(2'd0, 5'd19, 5'd0)}, 32'd7);
    check("model_sub", {27'd0, calc_z(2'd2, 5'd3, 5'd5)}, 32'd30);
    check("model_mul", {27'd0, calc_z(2'd3, 5'd7, 5'd6)}, 32'd10);

    // Fill the queue while the calculator is still initializing.
    base = n_results;
    for (int i = 0; i < 5; i++) begin
      push(i_op[i], i_a[i], i_b[i], ok);
      if (i < 4) check("init_accept", {31'd0, ok}, 32'd1);
      else       check("init_full_reject", {31'd0, ok}, 32'd0);
    end
    check("ready_low_when_full", {31'd0, cmd_ready}, 32'd0);
    repeat (5) @(negedge Clk);
    check("no_issue_in_init", rise_cnt, 0);
    Initializing = 1'b0;
    wait_results(base + 4, 300, "init_drain");
    check("init_queue_empty", mq.size(), 0);

    // Basic add with latency pinned.
    base       = n_results;
    resp_delay = 3;
    push(2'd1, 5'd4, 5'd3, ok);
    check("lat_cycle1_low", {31'd0, OpCodeValid}, 32'd0);
    @(negedge Clk);
    check("lat_cycle2_high", {31'd0, OpCodeValid}, 32'd1);
    wait_rv(100, "add_rv");
    check("add_data", {27'd0, res_data}, 32'd7);
    check("add_op", {30'd0, res_op}, 32'd1);
    check("add_err", {31'd0, res_err}, 32'd0);
    wait_results(base + 1, 50, "add_done");

    // Other opcodes.
    resp_delay = 1;
    for (int i = 0; i < 3; i++) begin
      base = n_results;
      push(p_op[i], p_a[i], p_b[i], ok);
      wait_rv(100, "pat_rv");
      check("pat_data", {27'd0, res_data}, {27'd0, p_z[i]});
      check("pat_op", {30'd0, res_op}, {30'd0, p_op[i]});
      wait_results(base + 1, 50, "pat_done");
    end

    // Calculator never answers.
    calc_mode = 1;
    base      = n_results;
    push(2'd1, 5'd1, 5'd1, ok);
    wait_rv(200, "tmo_rv");
    check("tmo_err", {31'd0, res_err}, 32'd1);
    check("tmo_data", {27'd0, res_data}, 32'd0);
    wait_results(base + 1, 50, "tmo_done");
    calc_mode = 0;

    // Result back-pressure with two commands queued behind it.
    res_ready  = 1'b0;
    resp_delay = 2;
    base       = n_results;
    push(2'd1, 5'd10, 5'd5, ok);
    push(2'd2, 5'd9, 5'd4, ok);
    push(2'd3, 5'd3, 5'd3, ok);
    wait_rv(100, "bp_rv");
    r0 = rise_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("bp_hold", {31'd0, res_valid}, 32'd1);
    end
    check("bp_no_issue", rise_cnt, r0);
    res_ready = 1'b1;
    wait_results(base + 3, 300, "bp_done");

    // DataReady left high by one op must not complete the next.
    resp_delay = 1;
    hold_dr    = 1'b1;
    base       = n_results;
    push(2'd1, 5'd2, 5'd2, ok);
    wait_results(base + 1, 100, "hold_first_done");
    calc_mode = 1;
    push(2'd2, 5'd8, 5'd1, ok);
    wait_rv(200, "hold_rv");
    check("hold_no_complete", {31'd0, res_err}, 32'd1);
    wait_results(base + 2, 50, "hold_done");
    hold_dr = 1'b0;
    @(negedge Clk);

    // Initializing raised during WAIT aborts, then the FSM parks in INIT.
    abort_flag = 1'b1;
    base       = n_results;
    push(2'd3, 5'd5, 5'd5, ok);
    wait_ov(1'b1, 20, "abort_ov_high");
    wait_ov(1'b0, 20, "abort_ov_low");
    repeat (5) @(negedge Clk);
    Initializing = 1'b1;
    wait_rv(20, "abort_rv");
    check("abort_err", {31'd0, res_err}, 32'd1);
    check("abort_data", {27'd0, res_data}, 32'd0);
    wait_results(base + 1, 20, "abort_done");
    abort_flag = 1'b0;
    calc_mode  = 0;
    resp_delay = 2;
    r0         = rise_cnt;
    push(2'd1, 5'd6, 5'd6, ok);
    repeat (5) @(negedge Clk);
    check("no_issue_after_abort", rise_cnt, r0);
    Initializing = 1'b0;
    wait_results(base + 2, 100, "abort_resume_done");

    // Reset in WAIT with three commands queued.
    calc_mode = 1;
    base      = n_results;
    for (int i = 0; i < 4; i++) push(2'(i), 5'(i + 1), 5'(i + 2), ok);
    r0 = rise_cnt;
    check("rst_in_wait", {31'd0, OpCodeValid}, 32'd0);
    check("rst_queued", mq.size(), 3);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (80) @(negedge Clk);
    check("rst_no_issue", rise_cnt, r0);
    check("rst_no_result", n_results, base);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_cmd_sequencer.md
CALC_CMD_SEQUENCER -- requirements
Module: calc_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, >=2).
REQ-002 SHALL have parameter VALID_CYCLES, default 2, number of cycles OpCodeValid is held per command (1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before a result is forced with error (2..255).
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  host command available.
REQ-007 cmd_ready  output  1  queue can accept a command.
REQ-008 cmd_op  input  2  opcode (00 rotate, 01 A+B, 10 A-B, 11 A*B).
REQ-009 cmd_a, cmd_b  input  5 each  operands.
REQ-010 A, B  output  5 each  operands to calculator.
REQ-011 OpCode  output  2  opcode to calculator.
REQ-012 OpCodeValid  output  1  operation strobe to calculator.
REQ-013 Z  input  5  calculator result.
REQ-014 DataReady  input  1  calculator result valid.
REQ-015 Initializing  input  1  calculator not ready for operations.
REQ-016 res_valid  output  1  result available; res_ready  input  1  consumer accepts.
REQ-017 res_data  output  5, res_op  output  2, res_err  output  1  result, its opcode, error flag.

Function
REQ-018 Command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_ready SHALL equal !fifo_full.
REQ-019 FIFO SHALL have no bypass; a command pushed into an empty FIFO SHALL be poppable the next cycle.
REQ-020 FSM states SHALL be INIT, IDLE, ISSUE, WAIT, RESULT.
REQ-021 INIT -> IDLE when Initializing==0; FIFO SHALL still accept commands in INIT.
REQ-022 IDLE with FIFO non-empty and Initializing==0 SHALL pop one entry, register A/B/OpCode, go ISSUE.
REQ-023 OpCodeValid SHALL be registered and high exactly for the VALID_CYCLES cycles in ISSUE; then go WAIT.
REQ-024 A, B, OpCode SHALL stay stable from pop until leaving RESULT.
REQ-025 DataReady SHALL be sampled into a delay register every cycle; completion = rising edge (prev 0, now 1) seen in ISSUE or WAIT; a level-high DataReady left over from a prior op SHALL NOT complete.
REQ-026 On completion Z SHALL be captured into res_data, res_err=0, go RESULT; res_valid high the next cycle.
REQ-027 WAIT timeout counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES-1 without completion: res_data=0, res_err=1, go RESULT.
REQ-028 Initializing==1 in ISSUE or WAIT SHALL abort: OpCodeValid low next cycle, res_data=0, res_err=1, go RESULT.
REQ-029 RESULT SHALL hold res_valid, res_data, res_op, res_err stable until res_ready==1; then go IDLE, or INIT if Initializing==1.
REQ-030 A new ISSUE SHALL NOT start while res_valid is high.
REQ-031 Completion and timeout in the same cycle SHALL resolve to completion; abort overrides both.
REQ-032 Latency: command into empty FIFO in IDLE at cycle 0 -> OpCodeValid high at cycle 2.

Reset
REQ-033 Rst SHALL set state INIT, FIFO empty (cmd_ready=1), A=B=0, OpCode=00, OpCodeValid=0, res_valid=0, res_data=0, res_op=00, res_err=0, counters 0, DataReady delay 0.
REQ-034 Rst mid-operation SHALL discard queued and in-flight commands with no result emitted.

Structure
REQ-035 Opcode encodings, FSM state encoding, and default parameter values SHALL reside in shared package calc_pkg.
REQ-036 Command queue SHALL be sub-module calc_cmd_fifo (synchronous, width 12, depth FIFO_DEPTH, full/empty flags).

Verification
REQ-037 A=4,B=3,op=01, DataReady pulse 3 cycles after OpCodeValid falls with Z=7 -> res_valid, res_data=7, res_op=01, res_err=0.
REQ-038 Initializing=1, push 5 commands -> cmd_ready low after 4th accept, no OpCodeValid; Initializing=0 -> 4 ops issued in order.
REQ-039 Command issued, DataReady never rises -> res_err=1, res_data=0 after 64 WAIT cycles.
REQ-040 res_ready held low 10 cycles with 2 queued -> result stable, no OpCodeValid until accepted.
REQ-041 Initializing raised in WAIT -> res_err=1, then INIT; DataReady held high from prior op -> no premature completion.
REQ-042 Rst asserted in WAIT with 3 queued -> all REQ-033 values next cycle, no result.
